// File: rtl/dma_sched.sv
// dma_sched: shares one AFU DMA read/write port between two clients, granting one
// transfer at a time round-robin. Define DMA_SCHED_PERF_EN for perf counter ports.
module dma_sched #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned SIZE_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*SIZE_WIDTH-1:0] req_size,
  output logic [1:0]              req_ready,
  output logic [1:0]              xfer_done,
  output logic [DATA_WIDTH-1:0]   c_rd_data,
  output logic [1:0]              c_rd_valid,
  input  logic [1:0]              c_rd_en,
  input  logic [2*DATA_WIDTH-1:0] c_wr_data,
  output logic [1:0]              c_wr_ready,
  input  logic [1:0]              c_wr_en,
  output logic [ADDR_WIDTH-1:0]   dma_rd_addr,
  output logic [ADDR_WIDTH-1:0]   dma_wr_addr,
  output logic [SIZE_WIDTH-1:0]   dma_rd_size,
  output logic [SIZE_WIDTH-1:0]   dma_wr_size,
  output logic                    dma_rd_go,
  output logic                    dma_wr_go,
  output logic                    dma_rd_en,
  output logic                    dma_wr_en,
  input  logic [DATA_WIDTH-1:0]   dma_rd_data,
  output logic [DATA_WIDTH-1:0]   dma_wr_data,
  input  logic                    dma_empty,
  input  logic                    dma_full,
  input  logic                    dma_rd_done,
  input  logic                    dma_wr_done
`ifdef DMA_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_lines,
  output logic [31:0]             perf_busy,
  output logic [31:0]             perf_stall
`endif
);

  // One extra bit so a full-size transfer never wraps the line counter.
  localparam int unsigned CNT_W = SIZE_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GO   = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic                  gnt;
  logic                  dir;
  logic                  rr_last;
  logic [SIZE_WIDTH-1:0] size_q;
  logic [CNT_W-1:0]      count;

  logic                  arb_gnt;
  logic [ADDR_WIDTH-1:0] arb_addr;
  logic [SIZE_WIDTH-1:0] arb_size;
  logic [DATA_WIDTH-1:0] sel_wr_data;
  logic                  room;
  logic                  beat;

  // Round-robin pick: a lone requester wins, a tie goes to the client not served last.
  always_comb begin
    arb_gnt = req_valid[1];
    if (req_valid == 2'b11) arb_gnt = ~rr_last;
    arb_addr    = arb_gnt ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
    arb_size    = arb_gnt ? req_size[SIZE_WIDTH +: SIZE_WIDTH] : req_size[0 +: SIZE_WIDTH];
    sel_wr_data = gnt ? c_wr_data[DATA_WIDTH +: DATA_WIDTH] : c_wr_data[0 +: DATA_WIDTH];
    room        = count < CNT_W'(size_q);
    beat        = dma_rd_en | dma_wr_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and handshake steering; everything is held at 0 while rst_n is low.
  always_comb begin
    state_nx    = state;
    req_ready   = 2'b00;
    xfer_done   = 2'b00;
    c_rd_valid  = 2'b00;
    c_wr_ready  = 2'b00;
    c_rd_data   = '0;
    dma_wr_data = '0;
    dma_rd_go   = 1'b0;
    dma_wr_go   = 1'b0;
    dma_rd_en   = 1'b0;
    dma_wr_en   = 1'b0;
    if (rst_n) begin
      case (state)
        S_IDLE: begin
          if (req_valid != 2'b00) state_nx = S_GO;
        end
        S_GO: begin
          req_ready[gnt] = 1'b1;
          if (size_q == '0) begin
            state_nx = S_DONE;
          end else begin
            dma_rd_go = ~dir;
            dma_wr_go = dir;
            state_nx  = S_XFER;
          end
        end
        S_XFER: begin
          if (dir) begin
            c_wr_ready[gnt] = ~dma_full & room;
            dma_wr_en       = c_wr_en[gnt] & ~dma_full & room;
            dma_wr_data     = sel_wr_data;
            if (!room && dma_wr_done) state_nx = S_DONE;
          end else begin
            c_rd_valid[gnt] = ~dma_empty & room;
            dma_rd_en       = c_rd_en[gnt] & ~dma_empty & room;
            c_rd_data       = dma_rd_data;
            if (!room && dma_rd_done) state_nx = S_DONE;
          end
        end
        S_DONE: begin
          xfer_done[gnt] = 1'b1;
          state_nx       = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Descriptor latch on grant, plus the line counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt         <= 1'b0;
      dir         <= 1'b0;
      rr_last     <= 1'b1;
      size_q      <= '0;
      count       <= '0;
      dma_rd_addr <= '0;
      dma_wr_addr <= '0;
      dma_rd_size <= '0;
      dma_wr_size <= '0;
    end else begin
      if (state == S_IDLE && req_valid != 2'b00) begin
        gnt         <= arb_gnt;
        rr_last     <= arb_gnt;
        dir         <= req_write[arb_gnt];
        size_q      <= arb_size;
        dma_rd_addr <= arb_addr;
        dma_wr_addr <= arb_addr;
        dma_rd_size <= arb_size;
        dma_wr_size <= arb_size;
      end
      if (state == S_XFER && beat) count <= count + CNT_W'(1);
      else if (state == S_DONE)    count <= '0;
    end
  end

`ifdef DMA_SCHED_PERF_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lines <= '0;
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (beat && perf_lines != '1) perf_lines <= perf_lines + 32'd1;
      if (state != S_IDLE && perf_busy != '1) perf_busy <= perf_busy + 32'd1;
      if (state == S_XFER && room && !beat && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_sched.sv
// Scoreboard bench for dma_sched: stimulus queues expected DUT events, a negedge
// monitor pops and compares each event the DUT presents.
`timescale 1ns/1ps
module tb_dma_sched;
  localparam int unsigned AW = 64;
  localparam int unsigned SW = 16;
  localparam int unsigned DW = 512;
  localparam logic [2:0] K_READY = 3'd1, K_RDGO = 3'd2, K_WRGO = 3'd3,
                         K_RDB = 3'd4, K_WRB = 3'd5, K_DONE = 3'd6;

  typedef struct packed {
    logic [2:0]  kind;
    logic [63:0] a;
    logic [31:0] b;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid, req_write, req_ready, xfer_done;
  logic [2*AW-1:0] req_addr;
  logic [2*SW-1:0] req_size;
  logic [DW-1:0]   c_rd_data, dma_rd_data, dma_wr_data;
  logic [1:0]      c_rd_valid, c_rd_en, c_wr_ready, c_wr_en;
  logic [2*DW-1:0] c_wr_data;
  logic [AW-1:0]   dma_rd_addr, dma_wr_addr;
  logic [SW-1:0]   dma_rd_size, dma_wr_size;
  logic            dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en;
  logic            dma_empty, dma_full, dma_rd_done, dma_wr_done;
`ifdef DMA_SCHED_PERF_EN
  logic [31:0]     perf_lines, perf_busy, perf_stall;
`endif

  ev_t         exp_q[$];
  int          total = 0;
  int          passed = 0;
  logic        tog = 1'b0;
  logic [31:0] rd_pat = 32'h0;

  assign dma_rd_data = {16{rd_pat}};

  dma_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_ready(req_ready), .xfer_done(xfer_done),
    .c_rd_data(c_rd_data), .c_rd_valid(c_rd_valid), .c_rd_en(c_rd_en),
    .c_wr_data(c_wr_data), .c_wr_ready(c_wr_ready), .c_wr_en(c_wr_en),
    .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
    .dma_rd_size(dma_rd_size), .dma_wr_size(dma_wr_size),
    .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
    .dma_rd_en(dma_rd_en), .dma_wr_en(dma_wr_en),
    .dma_rd_data(dma_rd_data), .dma_wr_data(dma_wr_data),
    .dma_empty(dma_empty), .dma_full(dma_full),
    .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done)
`ifdef DMA_SCHED_PERF_EN
    , .perf_lines(perf_lines), .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] wpat(input int c);
    return (c != 0) ? 32'hC1C1_0001 : 32'hC0C0_0000;
  endfunction

  function automatic logic [127:0] ctl_bits();
    return 128'({req_ready, xfer_done, c_rd_valid, c_wr_ready,
                 dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en});
  endfunction

  // Monitor: every event the DUT presents must match the head of the queue.
  task automatic obs(input logic [2:0] k, input logic [63:0] a, input logic [31:0] b);
    ev_t o;
    ev_t e;
    o = {k, a, b};
    if (exp_q.size() == 0) begin
      check("unexpected_event", 128'(o), 128'(0));
    end else begin
      e = exp_q.pop_front();
      check("event", 128'(o), 128'(e));
    end
  endtask

  always @(negedge clk) begin
    if (req_ready != 2'b00) obs(K_READY, 64'(req_ready), 32'd0);
    if (dma_rd_go)          obs(K_RDGO, dma_rd_addr, 32'(dma_rd_size));
    if (dma_wr_go)          obs(K_WRGO, dma_wr_addr, 32'(dma_wr_size));
    if (dma_rd_en)          obs(K_RDB, 64'(c_rd_valid), c_rd_data[31:0]);
    if (dma_wr_en)          obs(K_WRB, 64'(c_wr_ready), dma_wr_data[31:0]);
    if (xfer_done != 2'b00) obs(K_DONE, 64'(xfer_done), 32'd0);
  end

  task automatic push(input logic [2:0] k, input logic [63:0] a, input logic [31:0] b);
    exp_q.push_back({k, a, b});
  endtask

  // One clock; drops any req_valid bit whose req_ready was seen this cycle.
  task automatic step();
    logic [1:0] r;
    @(negedge clk);
    r = req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~r;
    if (tog) dma_empty = ~dma_empty;
  endtask

  task automatic wait_q(input int target, input int limit, input string name);
    int n = 0;
    while (exp_q.size() != target && n < limit) begin
      step();
      n++;
    end
    check(name, 128'(exp_q.size()), 128'(target));
  endtask

  task automatic post(input int c, input logic wr, input logic [63:0] addr, input logic [15:0] size);
    req_valid[c]          = 1'b1;
    req_write[c]          = wr;
    req_addr[c*AW +: AW]  = addr;
    req_size[c*SW +: SW]  = size;
  endtask

  task automatic expect_xfer(input int c, input logic wr, input logic [63:0] addr, input int size);
    push(K_READY, 64'(1) << c, 32'd0);
    if (size != 0) push(wr ? K_WRGO : K_RDGO, addr, 32'(size));
    for (int i = 0; i < size; i++)
      push(wr ? K_WRB : K_RDB, 64'(1) << c, wr ? wpat(c) : rd_pat);
  endtask

  task automatic finish_xfer(input int c, input logic wr);
    push(K_DONE, 64'(1) << c, 32'd0);
    if (wr) dma_wr_done = 1'b1;
    else    dma_rd_done = 1'b1;
    wait_q(0, 20, "done_wait");
    dma_wr_done = 1'b0;
    dma_rd_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    exp_q.delete();
    @(negedge clk);
    check("reset_ctl", ctl_bits(), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_addr", {dma_rd_addr, dma_wr_addr}, 128'(0));
    check("reset_misc", 128'({dma_rd_size, dma_wr_size, dma_wr_data[31:0], c_rd_data[31:0]}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_size = '0;
    c_rd_en = 2'b11; c_wr_en = 2'b11;
    c_wr_data = {{16{32'hC1C1_0001}}, {16{32'hC0C0_0000}}};
    dma_empty = 1'b0; dma_full = 1'b0; dma_rd_done = 1'b0; dma_wr_done = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // 1: client0 read of 4 lines with dma_empty toggling every cycle
    rd_pat = 32'hD000_0001;
    expect_xfer(0, 1'b0, 64'h1000, 4);
    post(0, 1'b0, 64'h1000, 16'd4);
    tog = 1'b1;
    wait_q(0, 60, "t1_beats");
    tog = 1'b0;
    dma_empty = 1'b0;
    push(K_DONE, 64'd1, 32'd0);
    dma_rd_done = 1'b1;
    @(negedge clk);
    check("t1_done_early", 128'(xfer_done), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_done_latency", 128'(xfer_done), 128'(2'b01));
    @(posedge clk); #1;
    dma_rd_done = 1'b0;
    wait_q(0, 5, "t1_drain");

    // 2: simultaneous requests, twice; client0 wins each round after reset
    do_reset();
    rd_pat = 32'hD000_0002;
    for (int r = 0; r < 2; r++) begin
      expect_xfer(0, 1'b1, 64'h2000, 2);
      post(0, 1'b1, 64'h2000, 16'd2);
      post(1, 1'b0, 64'h3000, 16'd3);
      wait_q(0, 20, "t2_c0_beats");
      finish_xfer(0, 1'b1);
      expect_xfer(1, 1'b0, 64'h3000, 3);
      wait_q(0, 20, "t2_c1_beats");
      finish_xfer(1, 1'b0);
    end

    // 4: zero-size request: ready then done on consecutive cycles, no go or beat
    push(K_READY, 64'd1, 32'd0);
    push(K_DONE, 64'd1, 32'd0);
    post(0, 1'b0, 64'h4000, 16'd0);
    wait_q(1, 20, "t4_ready");
    @(negedge clk);
    check("t4_done_next", 128'(xfer_done), 128'(2'b01));
    @(posedge clk); #1;
    wait_q(0, 5, "t4_drain");

    // 6: extra c_rd_en after the last line is ignored; DONE waits for dma_rd_done
    rd_pat = 32'hD000_0006;
    expect_xfer(0, 1'b0, 64'h6000, 2);
    post(0, 1'b0, 64'h6000, 16'd2);
    wait_q(0, 20, "t6_beats");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_hold", 128'({xfer_done, dma_rd_en, c_rd_valid}), 128'(0));
      @(posedge clk); #1;
    end
    finish_xfer(0, 1'b0);

    // 5: reset at count=2 of 8, then a fresh transfer restarts at count 0
    rd_pat = 32'hD000_0005;
    expect_xfer(0, 1'b0, 64'h5000, 8);
    post(0, 1'b0, 64'h5000, 16'd8);
    wait_q(6, 20, "t5_count2");
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t5_in_reset", ctl_bits(), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_after_reset", ctl_bits(), 128'(0));
    check("t5_addr_cleared", {dma_rd_addr, dma_wr_addr}, 128'(0));
    check("t5_data_cleared", 128'({dma_rd_size, c_rd_data[31:0]}), 128'(0));
    @(posedge clk); #1;
    expect_xfer(0, 1'b0, 64'h5100, 2);
    post(0, 1'b0, 64'h5100, 16'd2);
    wait_q(0, 20, "t5_new_beats");
    finish_xfer(0, 1'b0);

    // 3: client1 write of 3 with dma_full high for 5 cycles after the first line
    do_reset();
    expect_xfer(1, 1'b1, 64'h7000, 3);
    post(1, 1'b1, 64'h7000, 16'd3);
    wait_q(2, 20, "t3_first_line");
    dma_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_full_blocks", 128'({c_wr_ready, dma_wr_en}), 128'(0));
      @(posedge clk); #1;
    end
    dma_full = 1'b0;
    wait_q(0, 20, "t3_beats");
    finish_xfer(1, 1'b1);
`ifdef DMA_SCHED_PERF_EN
    check("t3_perf_lines", 128'(perf_lines), 128'(3));
    check("t3_perf_stall", 128'(perf_stall), 128'(5));
    check("t3_perf_busy", 128'(perf_busy), 128'(11));
`endif

    repeat (3) step();
    check("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
